// File: rtl/uart_mem_loader.sv
// Byte-stream loader/dumper: packs UART bytes into words across memory banks (LOAD)
// and streams every stored word back out byte by byte (DUMP).
module uart_mem_loader #(
  parameter int WORD_BYTES = 4,
  parameter int NUM_BANKS  = 2,
  parameter int DEPTH      = 64,
  parameter int MSB_FIRST  = 0,
  parameter int GAP_CLKS   = 0,
  localparam int AW = $clog2(DEPTH),
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int DW = 8 * WORD_BYTES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          dump_start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  output logic          tx_valid,
  output logic [7:0]    tx_byte,
  input  logic          tx_ready,
  output logic          mem_we,
  output logic          mem_re,
  output logic [BW-1:0] mem_bank,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          load_done,
  output logic          dump_done,
  output logic          overflow
);
  localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, RD, WAIT, SEND, GAP} state_t;
  typedef logic [WORD_BYTES-1:0][7:0] word_t;

  state_t        state, state_d;
  logic [CW-1:0] byte_cnt, cnt_inc;
  logic [GW-1:0] gap_cnt;
  word_t         word_buf, wmerge, rd_word;
  logic          last_lane, last_word, tx_fire, gap_end;
  logic [AW-1:0] addr_nx;
  logic [BW-1:0] bank_nx;

  // Wire order to byte lane; identical for load and dump so a round trip is identity.
  function automatic logic [CW-1:0] lane(input logic [CW-1:0] c);
    return (MSB_FIRST != 0) ? CW'(WORD_BYTES - 1) - c : c;
  endfunction

  assign rd_word   = mem_rdata;
  assign last_lane = byte_cnt == CW'(WORD_BYTES - 1);
  assign cnt_inc   = last_lane ? '0 : byte_cnt + 1'b1;
  assign last_word = (mem_bank == BW'(NUM_BANKS - 1)) && (mem_addr == AW'(DEPTH - 1));
  assign tx_fire   = tx_valid && tx_ready;
  assign gap_end   = int'(gap_cnt) == GAP_CLKS - 1;
  assign busy      = state != IDLE;

  always_comb begin
    wmerge = word_buf;
    wmerge[lane(byte_cnt)] = rx_byte;
    if (mem_addr == AW'(DEPTH - 1)) begin
      addr_nx = '0;
      bank_nx = (mem_bank == BW'(NUM_BANKS - 1)) ? '0 : mem_bank + 1'b1;
    end else begin
      addr_nx = mem_addr + 1'b1;
      bank_nx = mem_bank;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (load_start) state_d = LOAD;
            else if (dump_start) state_d = RD;
      LOAD: if (mem_we && last_word) state_d = IDLE;
      RD:   state_d = WAIT;
      WAIT: state_d = SEND;
      SEND: if (tx_fire) begin
              if (last_lane && last_word) state_d = IDLE;
              else if (GAP_CLKS > 0)      state_d = GAP;
              else if (last_lane)         state_d = RD;
            end
      // byte_cnt already wrapped to 0 means the gap closed out a word
      GAP:  if (gap_end) state_d = (byte_cnt == '0) ? RD : SEND;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      word_buf  <= '0;
      tx_valid  <= 1'b0;
      tx_byte   <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_bank  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_done <= 1'b0;
      dump_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        IDLE: if (load_start || dump_start) begin
                byte_cnt  <= '0;
                mem_addr  <= '0;
                mem_bank  <= '0;
                load_done <= 1'b0;
                dump_done <= 1'b0;
                if (load_start) overflow <= 1'b0;
                else            mem_re   <= 1'b1;
              end
        LOAD: begin
                if (rx_valid) begin
                  word_buf <= wmerge;
                  byte_cnt <= cnt_inc;
                  if (last_lane) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= wmerge;
                  end
                end
                if (mem_we) begin
                  mem_addr <= addr_nx;
                  mem_bank <= bank_nx;
                  if (last_word) load_done <= 1'b1;
                end
              end
        WAIT: begin
                word_buf <= rd_word;
                tx_valid <= 1'b1;
                tx_byte  <= rd_word[lane(byte_cnt)];
              end
        SEND: if (tx_fire) begin
                byte_cnt <= cnt_inc;
                gap_cnt  <= '0;
                tx_valid <= 1'b0;
                if (last_lane) begin
                  mem_addr <= addr_nx;
                  mem_bank <= bank_nx;
                  if (last_word)          dump_done <= 1'b1;
                  else if (GAP_CLKS == 0) mem_re    <= 1'b1;
                end else if (GAP_CLKS == 0) begin
                  tx_valid <= 1'b1;
                  tx_byte  <= word_buf[lane(cnt_inc)];
                end
              end
        GAP:  begin
                gap_cnt <= gap_cnt + 1'b1;
                if (gap_end) begin
                  if (byte_cnt == '0) mem_re <= 1'b1;
                  else begin
                    tx_valid <= 1'b1;
                    tx_byte  <= word_buf[lane(byte_cnt)];
                  end
                end
              end
        default: ;
      endcase
      if (rx_valid && state != LOAD) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomized self-checking bench for uart_mem_loader against a stream-level reference model.
module tb_uart_mem_loader;
  localparam int WB = 4, NB = 2, DP = 4, GAP = 2, NBYTES = WB * NB * DP, NWORDS = NB * DP;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic load_start = 0, dump_start = 0, rx_valid = 0, tx_ready = 0;
  logic [7:0] rx_byte = 0;
  logic tx_valid, mem_we, mem_re, busy, load_done, dump_done, overflow;
  logic [7:0] tx_byte;
  logic [0:0] mem_bank;
  logic [1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = 0;
  logic tx_valid_m, mem_we_m, mem_re_m, busy_m, load_done_m, dump_done_m, overflow_m;
  logic [7:0] tx_byte_m;
  logic [0:0] mem_bank_m;
  logic [1:0] mem_addr_m;
  logic [31:0] mem_wdata_m, mem_rdata_m = 0;

  uart_mem_loader #(.WORD_BYTES(WB), .NUM_BANKS(NB), .DEPTH(DP), .MSB_FIRST(0), .GAP_CLKS(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .dump_start(dump_start),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .tx_ready(tx_ready), .mem_we(mem_we), .mem_re(mem_re), .mem_bank(mem_bank),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .load_done(load_done), .dump_done(dump_done), .overflow(overflow));

  uart_mem_loader #(.WORD_BYTES(WB), .NUM_BANKS(NB), .DEPTH(DP), .MSB_FIRST(1), .GAP_CLKS(GAP)) dut_m (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .dump_start(dump_start),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_valid(tx_valid_m), .tx_byte(tx_byte_m),
    .tx_ready(tx_ready), .mem_we(mem_we_m), .mem_re(mem_re_m), .mem_bank(mem_bank_m),
    .mem_addr(mem_addr_m), .mem_wdata(mem_wdata_m), .mem_rdata(mem_rdata_m), .busy(busy_m),
    .load_done(load_done_m), .dump_done(dump_done_m), .overflow(overflow_m));

  // Behavioural memories: write on mem_we, read data one cycle after mem_re.
  logic [31:0] mem [NB][DP];
  logic [31:0] mem_mm [NB][DP];
  always @(posedge clk) begin
    if (mem_we)   mem[mem_bank][mem_addr] <= mem_wdata;
    if (mem_re)   mem_rdata <= mem[mem_bank][mem_addr];
    if (mem_we_m) mem_mm[mem_bank_m][mem_addr_m] <= mem_wdata_m;
    if (mem_re_m) mem_rdata_m <= mem_mm[mem_bank_m][mem_addr_m];
  end

  typedef struct packed {logic [0:0] bank; logic [1:0] addr; logic [31:0] data;} wr_t;
  wr_t wq[$], wq_m[$];
  logic [7:0] txq[$], txq_m[$];
  int gapq[$];
  int idle, unstable;
  bit counting, prev_valid, prev_fire;
  logic [7:0] prev_byte;
  logic [7:0] stream [NBYTES];
  int checks = 0, failures = 0;

  always @(negedge clk) begin
    if (mem_we)   wq.push_back({mem_bank, mem_addr, mem_wdata});
    if (mem_we_m) wq_m.push_back({mem_bank_m, mem_addr_m, mem_wdata_m});
    if (tx_valid_m && tx_ready) txq_m.push_back(tx_byte_m);
    if (counting) begin
      if (tx_valid) begin gapq.push_back(idle); counting = 0; end
      else idle++;
    end
    if (prev_valid && !prev_fire && (!tx_valid || tx_byte !== prev_byte)) unstable++;
    if (tx_valid && tx_ready) begin txq.push_back(tx_byte); counting = 1; idle = 0; end
    prev_valid = tx_valid && rst_n;
    prev_fire  = tx_valid && tx_ready;
    prev_byte  = tx_byte;
  end

  function automatic wr_t exp_wr(int k, bit msb);
    wr_t e;
    e.bank = 1'(k / DP);
    e.addr = 2'(k % DP);
    e.data = msb ? {stream[4*k], stream[4*k+1], stream[4*k+2], stream[4*k+3]}
                 : {stream[4*k+3], stream[4*k+2], stream[4*k+1], stream[4*k]};
    return e;
  endfunction

  task automatic clear_mon();
    wq.delete(); wq_m.delete(); txq.delete(); txq_m.delete(); gapq.delete();
    counting = 0; unstable = 0;
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rand_stream();
    for (int i = 0; i < NBYTES; i++) stream[i] = 8'($urandom);
  endtask

  task automatic pulse_load();
    load_start = 1; tick(); load_start = 0;
  endtask

  task automatic feed(input int from, input int to);
    for (int i = from; i < to; i++) begin
      rx_valid = 1; rx_byte = stream[i]; tick(); rx_valid = 0;
      tick($urandom_range(0, 2));
    end
  endtask

  task automatic drain(input int lo, input int hi, output bit timeout);
    timeout = 0;
    for (int i = 0; i < NBYTES && !timeout; i++) begin
      int n = 0;
      while (!tx_valid && n < 50) begin tick(); n++; end
      if (!tx_valid) timeout = 1;
      else begin
        tick($urandom_range(lo, hi));
        tx_ready = 1; tick(); tx_ready = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 0; load_start = 0; dump_start = 0; rx_valid = 0; tx_ready = 0;
    tick(2); rst_n = 1; tick();
  endtask

  task automatic check_writes(input string tag);
    for (int k = 0; k < NWORDS; k++) begin
      checks++;
      if (k >= wq.size() || wq[k] !== exp_wr(k, 0)) begin
        failures++;
        $display("FAIL %s lsb_write[%0d] got=%h exp=%h", tag, k, (k < wq.size()) ? wq[k] : '0, exp_wr(k, 0));
      end
      checks++;
      if (k >= wq_m.size() || wq_m[k] !== exp_wr(k, 1)) begin
        failures++;
        $display("FAIL %s msb_write[%0d] got=%h exp=%h", tag, k, (k < wq_m.size()) ? wq_m[k] : '0, exp_wr(k, 1));
      end
    end
    checks++;
    if (wq.size() != NWORDS || wq_m.size() != NWORDS) begin
      failures++; $display("FAIL %s write_count got=%0d/%0d exp=%0d", tag, wq.size(), wq_m.size(), NWORDS);
    end
  endtask

  task automatic check_dump(input string tag, input bit timeout);
    checks++;
    if (timeout) begin failures++; $display("FAIL %s tx_timeout got=1 exp=0", tag); end
    for (int i = 0; i < NBYTES; i++) begin
      checks++;
      if (i >= txq.size() || txq[i] !== stream[i] || i >= txq_m.size() || txq_m[i] !== stream[i]) begin
        failures++;
        $display("FAIL %s tx_byte[%0d] got=%h/%h exp=%h", tag, i, (i < txq.size()) ? txq[i] : 8'h0,
                 (i < txq_m.size()) ? txq_m[i] : 8'h0, stream[i]);
      end
    end
    for (int i = 0; i < NBYTES - 1; i++) begin
      int eg = (i % WB == WB - 1) ? GAP + 2 : GAP;
      checks++;
      if (i >= gapq.size() || gapq[i] != eg) begin
        failures++; $display("FAIL %s gap[%0d] got=%0d exp=%0d", tag, i, (i < gapq.size()) ? gapq[i] : -1, eg);
      end
    end
    checks++;
    if (unstable != 0) begin failures++; $display("FAIL %s tx_stable got=%0d exp=0", tag, unstable); end
    checks++;
    if ({dump_done, dump_done_m, busy} !== 3'b110) begin
      failures++; $display("FAIL %s dump_done/busy got=%b exp=110", tag, {dump_done, dump_done_m, busy});
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({tx_valid, tx_byte, mem_we, mem_re, mem_bank, mem_addr, mem_wdata, busy, load_done, dump_done, overflow,
         tx_valid_m, mem_we_m, mem_re_m, mem_wdata_m, busy_m} !== '0) begin
      failures++; $display("FAIL reset_outputs got=nonzero exp=0");
    end
    @(negedge clk); rst_n = 1; tick(2);
    checks++;
    if ({busy, mem_we, mem_re, tx_valid} !== 4'b0) begin
      failures++; $display("FAIL reset_idle got=%b exp=0000", {busy, mem_we, mem_re, tx_valid});
    end
  endtask

  task automatic test_load();
    clear_mon();
    for (int i = 0; i < NBYTES; i++) stream[i] = 8'(i);
    pulse_load();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL load_busy got=%b exp=1", busy); end
    feed(0, NBYTES - 1);
    rx_valid = 1; rx_byte = stream[NBYTES-1]; tick(); rx_valid = 0;
    checks++;
    if ({mem_we, mem_bank, mem_addr, mem_wdata} !== {1'b1, 1'b1, 2'd3, 32'h1F1E1D1C}) begin
      failures++; $display("FAIL final_write got=%b %0d %0d %h exp=1 1 3 1f1e1d1c", mem_we, mem_bank, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if ({mem_we, load_done, busy, mem_bank, mem_addr} !== {1'b0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      failures++; $display("FAIL load_done got=we%b done%b busy%b b%0d a%0d exp=we0 done1 busy0 b0 a0",
                           mem_we, load_done, busy, mem_bank, mem_addr);
    end
    tick(3);
    checks++;
    if (wq_m.size() < 1 || wq_m[0].data !== 32'h00010203) begin
      failures++; $display("FAIL msb_first_word got=%h exp=00010203", (wq_m.size() > 0) ? wq_m[0].data : 32'h0);
    end
    check_writes("load_seq");
  endtask

  task automatic test_dump();
    bit to;
    clear_mon();
    dump_start = 1; tick(); dump_start = 0;
    checks++;
    if ({mem_re, busy, load_done} !== 3'b110) begin
      failures++; $display("FAIL dump_rd got=%b exp=110", {mem_re, busy, load_done});
    end
    tick();
    checks++;
    if ({mem_re, tx_valid} !== 2'b00) begin failures++; $display("FAIL dump_wait got=%b exp=00", {mem_re, tx_valid}); end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== stream[0]) begin
      failures++; $display("FAIL dump_first got=%b %h exp=1 %h", tx_valid, tx_byte, stream[0]);
    end
    drain(5, 5, to);
    tick(2);
    check_dump("dump_stall", to);
  endtask

  task automatic test_overflow();
    clear_mon();
    rx_valid = 1; rx_byte = 8'($urandom); tick(); rx_valid = 0;
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b exp=1", overflow); end
    tick(2);
    checks++;
    if (wq.size() != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL overflow_nowrite got=%0d busy%b exp=0 busy0", wq.size(), busy);
    end
    pulse_load();
    checks++;
    if ({overflow, busy, dump_done} !== 3'b010) begin
      failures++; $display("FAIL overflow_clear got=%b exp=010", {overflow, busy, dump_done});
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    clear_mon();
    rand_stream();
    pulse_load();
    feed(0, 6);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({tx_valid, tx_byte, mem_we, mem_re, mem_bank, mem_addr, mem_wdata, busy, load_done, dump_done, overflow,
         mem_wdata_m, busy_m} !== '0) begin
      failures++; $display("FAIL midload_reset got=nonzero exp=0");
    end
    @(negedge clk); rst_n = 1;
    tick(4);
    checks++;
    if (wq.size() != 1 || wq[0] !== exp_wr(0, 0)) begin
      failures++; $display("FAIL partial_discard got=%0d writes exp=1", wq.size());
    end
    clear_mon();
    rand_stream();
    pulse_load();
    feed(0, NBYTES);
    tick(3);
    checks++;
    if (load_done !== 1'b1) begin failures++; $display("FAIL fresh_load_done got=%b exp=1", load_done); end
    check_writes("fresh_load");
  endtask

  task automatic test_start_priority();
    clear_mon();
    rand_stream();
    load_start = 1; dump_start = 1; tick(); load_start = 0; dump_start = 0;
    checks++;
    if ({busy, mem_re, load_done} !== 3'b100) begin
      failures++; $display("FAIL both_start got=%b exp=100", {busy, mem_re, load_done});
    end
    tick();
    dump_start = 1; tick(); dump_start = 0;
    tick();
    checks++;
    if ({mem_re, tx_valid, busy} !== 3'b001) begin
      failures++; $display("FAIL dump_ignored got=%b exp=001", {mem_re, tx_valid, busy});
    end
    feed(0, NBYTES);
    tick(3);
    checks++;
    if ({load_done, dump_done, busy} !== 3'b100) begin
      failures++; $display("FAIL priority_done got=%b exp=100", {load_done, dump_done, busy});
    end
    check_writes("priority_load");
  endtask

  task automatic test_random_roundtrip();
    for (int it = 0; it < 2; it++) begin
      bit to;
      clear_mon();
      rand_stream();
      pulse_load();
      feed(0, NBYTES);
      tick(3);
      check_writes("rand_load");
      clear_mon();
      dump_start = 1; tick(); dump_start = 0;
      drain(0, 3, to);
      tick(2);
      check_dump("rand_dump", to);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_dump();
    test_overflow();
    test_reset_midload();
    test_start_priority();
    test_random_roundtrip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

Parametrised byte-stream loader/dumper between the UART byte interfaces and a bank of word memories. In LOAD mode it packs received bytes into words and writes them sequentially across `NUM_BANKS` banks of `DEPTH` words each. In DUMP mode it reads every word back and streams its bytes to the UART transmitter under a valid/ready handshake with programmable inter-byte gap. It sits between `uart_rx`/`uart_tx` and the instruction/data memories, replacing fixed-size, fixed-timing loader control.

## Interface
Parameters:
- `WORD_BYTES`, 4: bytes per memory word, 1..8
- `NUM_BANKS`, 2: number of memory banks, ≥1
- `DEPTH`, 64: words per bank, ≥2
- `MSB_FIRST`, 0: 0 = first byte on the wire is word bits [7:0]; 1 = first byte is the top byte
- `GAP_CLKS`, 0: idle cycles inserted after each accepted TX byte before the next `tx_valid`
- Derived: `AW` = clog2(`DEPTH`); `BW` = max(1, clog2(`NUM_BANKS`)); `DW` = 8*`WORD_BYTES`

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `load_start` in 1: one-cycle request, begin LOAD (ignored unless IDLE)
- `dump_start` in 1: one-cycle request, begin DUMP (ignored unless IDLE)
- `rx_valid` in 1: one-cycle strobe, `rx_byte` valid
- `rx_byte` in 8: received byte
- `tx_valid` out 1: `tx_byte` valid; held until accepted
- `tx_byte` out 8: byte to transmit; stable while `tx_valid`
- `tx_ready` in 1: transmitter accepts on `tx_valid && tx_ready`
- `mem_we` out 1: one-cycle write strobe
- `mem_re` out 1: one-cycle read strobe; `mem_rdata` valid the following cycle
- `mem_bank` out `BW`: bank select
- `mem_addr` out `AW`: word address within bank
- `mem_wdata` out `DW`: write data
- `mem_rdata` in `DW`: read data from selected bank
- `busy` out 1: high in any state other than IDLE
- `load_done` out 1: sticky, set on final write; cleared by next `load_start` or `dump_start` acceptance
- `dump_done` out 1: sticky, set on final byte acceptance; cleared by next start acceptance
- `overflow` out 1: sticky, `rx_valid` seen while not in LOAD; cleared only by accepted `load_start`

## Operation
- States: IDLE, LOAD, RD, WAIT, SEND, GAP.
- IDLE: `load_start` → LOAD; else `dump_start` → RD. LOAD wins if both are asserted. Acceptance clears byte counter, `mem_addr`, `mem_bank` and both done flags; `load_start` also clears `overflow`.
- LOAD: each `rx_valid` stores `rx_byte` into byte lane `byte_cnt` (lane index reversed when `MSB_FIRST`=1) and increments `byte_cnt`.
  - On lane `WORD_BYTES`-1: next cycle `mem_we`=1 with the full word on `mem_wdata` at the current bank/addr.
  - Then `mem_addr`+1. At `DEPTH`-1 the address wraps to 0 and `mem_bank`+1.
  - Write of bank `NUM_BANKS`-1, addr `DEPTH`-1 → IDLE, `load_done`=1, bank/addr return to 0.
- DUMP:
  - RD: `mem_re`=1 one cycle → WAIT.
  - WAIT: latch `mem_rdata` → SEND.
  - SEND: `tx_valid`=1, `tx_byte` = lane `byte_cnt` (same lane order as LOAD, so a round trip is identity). On accept: `byte_cnt`+1, → GAP if `GAP_CLKS`>0, else continue.
  - After last lane: advance bank/addr as in LOAD and → RD. After last word → IDLE, `dump_done`=1.
- `rx_valid` outside LOAD: byte discarded, `overflow`=1.
- Starts during `busy` are ignored. No abort path.
- Reset mid-operation: immediate return to IDLE, all state cleared; a partial word is discarded and never written.

## Timing
- Reset values: every output 0. `busy`, done flags and `overflow` are 0.
- `load_start` at cycle t → `busy`=1 at t+1.
- `rx_valid` of last lane at cycle t → `mem_we`=1 at t+1 (exactly one cycle); `load_done` and `busy`=0 at t+2 after the final word.
- `dump_start` at t → `mem_re` at t+1 → rdata latched at t+2 → `tx_valid` at t+3.
- Byte accepted at cycle a → next `tx_valid` at a+1+`GAP_CLKS` within a word. Across a word boundary, the next `tx_valid` is at a+3+`GAP_CLKS` (RD and WAIT inserted).
- `tx_byte`, `mem_*` address/data are registered, with no combinational path from inputs.
- `tx_valid` never drops without acceptance, except on reset.

## Test plan
Bench parameters: `WORD_BYTES`=4, `NUM_BANKS`=2, `DEPTH`=4, `GAP_CLKS`=2.
- Load 32 bytes 0x00..0x1F, `MSB_FIRST`=0 → 8 writes: bank0 addr0 = 0x03020100 … bank1 addr3 = 0x1F1E1D1C; `load_done`=1 after the last write; no extra `mem_we`.
- Same stream with `MSB_FIRST`=1 → bank0 addr0 = 0x00010203.
- Dump after load with `tx_ready` stalled 5 cycles per byte → 32 bytes 0x00..0x1F in order, `tx_byte` stable while stalled, gaps ≥2 idle cycles, `dump_done`=1.
- `rx_valid` in IDLE → `overflow`=1, no `mem_we`. Then `load_start` → `overflow`=0.
- `load_start` and `dump_start` in the same cycle → LOAD entered. `dump_start` while busy → ignored.
- `rst_n` low after 6 bytes of a load → all outputs 0 immediately, no write of the partial word. A fresh load then starts at bank0 addr0.
